// File: rtl/pw_equal_n_if.sv
// Spike-side bundle of the N-channel temporal equal primitive: input spikes
// from the race-logic fabric and the equal result returned to it.
interface pw_equal_n_if #(
  parameter int N_CH = 2,
  parameter int TW   = 4
);
  logic [N_CH-1:0] in_ch;
  logic            y;
  logic            y_valid;
  logic [TW-1:0]   t_out;
  logic            gamma_start;

  modport master (
    output in_ch,
    input  y,
    input  y_valid,
    input  t_out,
    input  gamma_start
  );

  modport slave (
    input  in_ch,
    output y,
    output y_valid,
    output t_out,
    output gamma_start
  );
endinterface

// File: rtl/pw_equal_n.sv
// N-channel temporal "equal" for pulse-width-encoded spikes: y pulses when every
// channel rises within TOL cycles of the first arrival inside one gamma cycle.
module pw_equal_n #(
  parameter int N_CH              = 2,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int TOL               = 0
) (
  input  logic         aclk,
  input  logic         grst,
  pw_equal_n_if.slave  bus
);
  localparam int TW = $clog2(GAMMA_CYCLE_WIDTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_FIRE    = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [TW-1:0]   GMAX   = TW'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [TW-1:0]   PW_C   = TW'(PULSE_WIDTH);
  localparam logic [TW-1:0]   ONE_C  = TW'(1);
  localparam logic [TW-1:0]   ZERO_C = TW'(0);
  localparam logic [TW:0]     TOL_C  = (TW + 1)'(TOL);
  localparam logic [N_CH-1:0] ALL_C  = {N_CH{1'b1}};
  localparam logic [N_CH-1:0] NONE_C = {N_CH{1'b0}};

  logic [TW-1:0]   gcnt_r;
  logic [N_CH-1:0] in_q_r;
  logic [1:0]      state_r;
  logic [N_CH-1:0] mask_r;
  logic [TW-1:0]   t0_r;
  logic [TW:0]     deadline_r;
  logic [TW-1:0]   pcnt_r;
  logic            y_r;
  logic            y_valid_r;
  logic [TW-1:0]   t_out_r;

  logic [N_CH-1:0] edge_s;
  logic [N_CH-1:0] mask_nx_s;
  logic            wrap_s;
  logic            in_win_s;

  // Rising-edge detect, window test and end-of-gamma decode.
  always_comb begin
    edge_s    = bus.in_ch & ~in_q_r;
    mask_nx_s = mask_r | edge_s;
    wrap_s    = (gcnt_r == GMAX);
    in_win_s  = ({1'b0, gcnt_r} <= deadline_r);
  end

  // Gamma counter and input history; history survives the wrap so a held level is not a new event.
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      gcnt_r <= ZERO_C;
      in_q_r <= NONE_C;
    end else begin
      gcnt_r <= wrap_s ? ZERO_C : (gcnt_r + ONE_C);
      in_q_r <= bus.in_ch;
    end
  end

  // Arrival collection and pulse generation; the wrap overrides everything so a pulse never spans gammas.
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      state_r    <= S_IDLE;
      mask_r     <= NONE_C;
      t0_r       <= ZERO_C;
      deadline_r <= {(TW + 1){1'b0}};
      pcnt_r     <= ZERO_C;
      y_r        <= 1'b0;
      y_valid_r  <= 1'b0;
      t_out_r    <= ZERO_C;
    end else if (wrap_s) begin
      state_r   <= S_IDLE;
      mask_r    <= NONE_C;
      pcnt_r    <= ZERO_C;
      y_r       <= 1'b0;
      y_valid_r <= 1'b0;
    end else begin
      y_valid_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (|edge_s) begin
            t0_r       <= gcnt_r;
            mask_r     <= edge_s;
            deadline_r <= {1'b0, gcnt_r} + TOL_C;
            if (edge_s == ALL_C) begin
              state_r   <= S_FIRE;
              y_r       <= 1'b1;
              y_valid_r <= 1'b1;
              t_out_r   <= gcnt_r;
              pcnt_r    <= ONE_C;
            end else begin
              state_r <= S_COLLECT;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_COLLECT: begin
          if (in_win_s && (mask_nx_s == ALL_C)) begin
            mask_r    <= mask_nx_s;
            state_r   <= S_FIRE;
            y_r       <= 1'b1;
            y_valid_r <= 1'b1;
            t_out_r   <= t0_r;
            pcnt_r    <= ONE_C;
          end else if (!in_win_s) begin
            state_r <= S_DONE;
          end else begin
            mask_r <= mask_nx_s;
          end
        end
        S_FIRE: begin
          if (pcnt_r == PW_C) begin
            y_r     <= 1'b0;
            state_r <= S_DONE;
          end else begin
            pcnt_r <= pcnt_r + ONE_C;
          end
        end
        S_DONE: begin
          y_r <= 1'b0;
        end
        default: begin
          state_r <= S_IDLE;
          y_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.y           = y_r;
  assign bus.y_valid     = y_valid_r;
  assign bus.t_out       = t_out_r;
  assign bus.gamma_start = (gcnt_r == ZERO_C);

endmodule

// File: tb/tb_pw_equal_n.sv
// Bench for pw_equal_n: a 2-channel exact-equality instance and a 3-channel
// TOL=2 instance, checked every cycle against an arrival-time model.
module tb_pw_equal_n;
  localparam int G  = 16;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  pw_equal_n_if #(.N_CH(2), .TW(4)) if2 ();
  pw_equal_n_if #(.N_CH(3), .TW(4)) if3 ();

  pw_equal_n #(.N_CH(2), .GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(PW), .TOL(0)) dut2 (
    .aclk(clk), .grst(rst), .bus(if2));
  pw_equal_n #(.N_CH(3), .GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(PW), .TOL(2)) dut3 (
    .aclk(clk), .grst(rst), .bus(if3));

  always #5 clk = ~clk;

  // Model: per gamma, first rise time of each channel; fire start gcnt; latched t_out.
  int       mg [2];
  int       ft [2][3];
  logic [2:0] pv [2];
  int       fst [2];
  int       pend_t0 [2];
  int       etout [2];
  int       ycnt2, yv2, ycnt3, yv3;

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mg[m] = 0; pv[m] = 3'b000; fst[m] = -1; pend_t0[m] = 0; etout[m] = 0;
      for (int c = 0; c < 3; c++) ft[m][c] = -1;
    end
  endtask

  task automatic mstep(input int m, input logic [2:0] v);
    int nch, tol, g, t0, tmax;
    bit all;
    nch = (m == 1) ? 3 : 2;
    tol = (m == 1) ? 2 : 0;
    g   = mg[m];
    for (int c = 0; c < nch; c++)
      if (v[c] && !pv[m][c] && ft[m][c] < 0) ft[m][c] = g;
    pv[m] = v;
    all = 1'b1; t0 = 1000; tmax = -1;
    for (int c = 0; c < nch; c++) begin
      if (ft[m][c] < 0) all = 1'b0;
      else begin
        if (ft[m][c] < t0)   t0   = ft[m][c];
        if (ft[m][c] > tmax) tmax = ft[m][c];
      end
    end
    if (all && tmax == g && fst[m] < 0 && tmax <= t0 + tol && g != G - 1) begin
      fst[m] = g + 1;
      pend_t0[m] = t0;
    end
    if (g == G - 1) begin
      mg[m] = 0; fst[m] = -1;
      for (int c = 0; c < 3; c++) ft[m][c] = -1;
    end else begin
      mg[m] = g + 1;
    end
    if (fst[m] >= 0 && mg[m] == fst[m]) etout[m] = pend_t0[m];
  endtask

  function automatic logic exp_y(input int m);
    return (fst[m] >= 0 && mg[m] >= fst[m] && mg[m] < fst[m] + PW);
  endfunction

  function automatic logic exp_v(input int m);
    return (fst[m] >= 0 && mg[m] == fst[m]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step(input logic [1:0] v2, input logic [2:0] v3);
    if2.in_ch = v2;
    if3.in_ch = v3;
    @(posedge clk);
    mstep(0, {1'b0, v2});
    mstep(1, v3);
    #1;
    chk("y2",  {31'd0, if2.y},           {31'd0, exp_y(0)});
    chk("yv2", {31'd0, if2.y_valid},     {31'd0, exp_v(0)});
    chk("t2",  {28'd0, if2.t_out},       etout[0]);
    chk("gs2", {31'd0, if2.gamma_start}, (mg[0] == 0) ? 32'd1 : 32'd0);
    chk("y3",  {31'd0, if3.y},           {31'd0, exp_y(1)});
    chk("yv3", {31'd0, if3.y_valid},     {31'd0, exp_v(1)});
    chk("t3",  {28'd0, if3.t_out},       etout[1]);
    chk("gs3", {31'd0, if3.gamma_start}, (mg[1] == 0) ? 32'd1 : 32'd0);
    ycnt2 += int'(if2.y); yv2 += int'(if2.y_valid);
    ycnt3 += int'(if3.y); yv3 += int'(if3.y_valid);
  endtask

  function automatic logic [15:0] pat(input int r, input int f);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 16; i++)
      if (i >= r && i < f) p[i] = 1'b1;
    return p;
  endfunction

  task automatic run_gamma(input logic [15:0] a0, input logic [15:0] a1,
                           input logic [15:0] b0, input logic [15:0] b1, input logic [15:0] b2);
    ycnt2 = 0; yv2 = 0; ycnt3 = 0; yv3 = 0;
    for (int g = 0; g < G; g++)
      step({a1[g], a0[g]}, {b2[g], b1[g], b0[g]});
  endtask

  function automatic logic [15:0] rand_pat(input int mode, input int base);
    int r;
    if ($urandom_range(0, 7) == 0) return 16'h0000;
    if (mode == 0) return 16'($urandom);
    r = base + ((mode == 1) ? 0 : $urandom_range(0, 3));
    return pat(r, r + $urandom_range(1, 16));
  endfunction

  initial begin
    logic [15:0] z;
    int mode, base;
    z = 16'h0000;
    if2.in_ch = 2'b00;
    if3.in_ch = 3'b000;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_y",  {31'd0, if2.y},           32'd0);
    chk("rst_yv", {31'd0, if2.y_valid},     32'd0);
    chk("rst_t",  {28'd0, if2.t_out},       32'd0);
    chk("rst_gs", {31'd0, if2.gamma_start}, 32'd1);
    rst = 1'b0;

    // Idle inputs for two gammas
    run_gamma(z, z, z, z, z);
    run_gamma(z, z, z, z, z);
    chk("idle_y", ycnt2 + ycnt3, 32'd0);

    // Arrivals too far apart, both orders
    run_gamma(pat(2, 15), pat(4, 15), pat(2, 15), pat(4, 15), pat(9, 15));
    chk("apart_y", ycnt2, 32'd0);
    chk("apart_yv", yv2, 32'd0);
    run_gamma(pat(4, 15), pat(2, 15), z, z, z);
    chk("swap_y", ycnt2, 32'd0);

    // Exact coincidence at t=2
    run_gamma(pat(2, 15), pat(2, 15), z, z, z);
    chk("eq_ycnt", ycnt2, 32'd8);
    chk("eq_yv", yv2, 32'd1);
    chk("eq_tout", {28'd0, if2.t_out}, 32'd2);

    // Three channels inside / outside the TOL=2 window
    run_gamma(z, z, pat(5, 15), pat(6, 15), pat(7, 15));
    chk("tol_ycnt", ycnt3, 32'd8);
    chk("tol_tout", {28'd0, if3.t_out}, 32'd5);
    run_gamma(z, z, pat(5, 15), pat(6, 15), pat(8, 15));
    chk("tol_late", ycnt3, 32'd0);

    // Pulse truncated by wrap, last-cycle arrival, level held across wrap
    run_gamma(pat(12, 16), pat(12, 16), z, z, z);
    chk("trunc_ycnt", ycnt2, 32'd3);
    chk("trunc_y0", {31'd0, if2.y}, 32'd0);
    run_gamma(pat(15, 16), pat(15, 16), z, z, z);
    chk("last_ycnt", ycnt2, 32'd0);
    chk("last_yv", yv2, 32'd0);
    run_gamma(pat(0, 1) | pat(3, 15), pat(0, 1) | pat(3, 15), z, z, z);
    chk("hold_ycnt", ycnt2, 32'd8);
    chk("hold_tout", {28'd0, if2.t_out}, 32'd3);

    // Asynchronous reset in the middle of a pulse
    for (int g = 0; g < 6; g++)
      step((g >= 2) ? 2'b11 : 2'b00, 3'b000);
    chk("pre_rst_y", {31'd0, if2.y}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_y",  {31'd0, if2.y},           32'd0);
    chk("arst_gs", {31'd0, if2.gamma_start}, 32'd1);
    chk("arst_t",  {28'd0, if2.t_out},       32'd0);
    if2.in_ch = 2'b00;
    if3.in_ch = 3'b000;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_gamma(pat(1, 15), pat(1, 15), z, z, z);
    chk("post_rst_ycnt", ycnt2, 32'd8);

    // Randomized gammas, near-coincident arrivals mixed with noise
    for (int k = 0; k < 60; k++) begin
      mode = $urandom_range(0, 2);
      base = $urandom_range(0, 15);
      run_gamma(rand_pat(mode, base), rand_pat(mode, base),
                rand_pat(mode, base), rand_pat(mode, base), rand_pat(mode, base));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
